clint_wb_responder: RTL and testbench
=====================================

Name: clint_wb_responder

Overview:
- Wishbone B4 classic responder implementing the core-local interruptor registers `msip`, `mtime` and `mtimecmp`.
- Sits on the memory bus opposite the core's Wishbone initiator.
- Drives `mem_msip`, `mem_mtime` and `mem_mtimecmp` straight into the core's interrupt inputs.
- Also provides decoded `software_interrupt` and `timer_interrupt` levels for the interrupt controller.

Parameters:
- `DATA_SIZE`, 32, bus data width; only 32 or 64 are legal.
- `CLOCK_CYCLES`, 1, clock cycles per `mtime` increment; must be ≥ 1.

Ports:
- `clock`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-low reset; the block is held in reset while `reset`=0.
- `CYC_I`  in  1  Wishbone cycle.
- `STB_I`  in  1  Wishbone strobe.
- `WE_I`  in  1  write enable.
- `SEL_I`  in  `DATA_SIZE`/8  byte lane selects.
- `ADR_I`  in  16  byte offset within the CLINT window.
- `DAT_I`  in  `DATA_SIZE`  write data.
- `DAT_O`  out  `DATA_SIZE`  read data, registered.
- `ACK_O`  out  1  Wishbone acknowledge, registered.
- `mem_msip`  out  `DATA_SIZE`  `msip` register, zero-extended.
- `mem_mtime`  out  64  `mtime` register.
- `mem_mtimecmp`  out  64  `mtimecmp` register.
- `software_interrupt`  out  1  equals `msip` bit 0.
- `timer_interrupt`  out  1  asserted when `mtime` ≥ `mtimecmp`, unsigned compare.

Behaviour:
- Reset values:
  - `msip` = 0.
  - `mtime` = 0.
  - `mtimecmp` = all ones.
  - prescaler = 0.
  - `ACK_O` = 0, `DAT_O` = 0.
  - FSM in IDLE.
  - As a result, `timer_interrupt` = 0 and `software_interrupt` = 0 out of reset.
- Address map (word-aligned; `ADR_I` low bits below the word size are ignored):
  - `0x0000` `msip`: only bit 0 is writable; other bits read 0.
  - `0x4000` `mtimecmp`: when `DATA_SIZE`=32, `0x4000` is the low word and `0x4004` the high word.
  - `0xBFF8` `mtime`: when `DATA_SIZE`=32, `0xBFF8` is the low word and `0xBFFC` the high word.
  - Any other offset reads 0, ignores writes, and is still acknowledged.
- Handshake FSM has two states, IDLE and ACK:
  - IDLE to ACK on a clock edge where `CYC_I` & `STB_I` = 1. At that same edge the read data is captured into `DAT_O`, or the write is committed.
  - ACK state: `ACK_O` = 1 for exactly one cycle, then unconditionally back to IDLE. Requests are not sampled in ACK.
  - Result: latency of 1 cycle from request to ACK. Back-to-back requests held high receive an ACK every second cycle.
- Outside an ACK cycle, `DAT_O` holds its last value.
- Writes are byte-masked by `SEL_I`; unselected bytes keep their current value. `SEL_I` is ignored on reads.
- `mtime` counting:
  - The prescaler counts 0 to `CLOCK_CYCLES`-1 and wraps.
  - `mtime` increments by 1 on each wrap.
  - `mtime` wraps from 2^64-1 to 0.
- Simultaneous write to `mtime` and increment: the write wins. New `mtime` = selected bytes from `DAT_I` merged over the pre-increment value. The increment is lost, and the prescaler keeps running.
- Write to one 32-bit half of `mtime`: the other half keeps the value it would have had without the write. There is no carry from the low half into the high half in that cycle.
- `timer_interrupt` and `software_interrupt` are combinational from the registers and update the cycle after a register changes.
- Reset asserted mid-transaction: all state returns to reset values immediately, and no ACK is produced for the aborted request.
- `CYC_I` dropped while in ACK: the ACK pulse still completes. The initiator ignores it.

Decomposition:
- Shared package or header holds:
  - offset constants `MSIP_OFFSET`, `MTIMECMP_OFFSET`, `MTIME_OFFSET`;
  - FSM state encodings IDLE and ACK;
  - the `mtimecmp` reset value.
- One sub-module, `mtime_counter`, contains:
  - the prescaler and 64-bit `mtime`;
  - a byte-masked write port;
  - the write-over-increment priority.
- The top level holds bus decode, the FSM, `msip`, and `mtimecmp`.

Test Plan:
- Release reset with `CLOCK_CYCLES`=1 and wait 10 cycles → `mem_mtime` = 10, `mem_mtimecmp` = 0xFFFFFFFFFFFFFFFF, `ACK_O` = 0, both interrupts 0.
- `DATA_SIZE`=32: write 0x1 to 0x0000 with `SEL_I`=0xF → `ACK_O` high exactly 1 cycle after STB; `software_interrupt` = 1; read of 0x0000 returns 0x00000001. Writing 0xFFFFFFFE → `msip` = 0.
- Write `mtimecmp` high = 0, low = 20 while `mtime` is counting → `timer_interrupt` rises on the first cycle `mtime` = 20. Rewriting low = 0xFFFFFFFF and high = 0xFFFFFFFF → `timer_interrupt` = 0.
- Write `mtime` low = 0xFFFFFFFF with `SEL_I`=0x3 in the same cycle as an increment tick → low word = 0x????FFFF using the pre-increment upper bytes; no increment in that cycle.
- Hold `CYC_I`/`STB_I` high for 6 cycles → exactly 3 single-cycle ACK pulses. Read of unmapped offset 0x1234 → `DAT_O` = 0, acknowledged.
- Drive `reset` low in the cycle between request and ACK → no ACK; registers back to reset values; normal operation after release.

Source files
------------

// File: rtl/clint_wb_responder_pkg.sv
// Shared definitions for the CLINT Wishbone responder: register offsets inside the
// CLINT window, handshake FSM state encoding, mtimecmp reset value and a byte-merge
// helper used by every byte-maskable register.
package clint_wb_responder_pkg;

  localparam logic [15:0] MSIP_OFFSET     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFFSET = 16'h4000;
  localparam logic [15:0] MTIME_OFFSET    = 16'hBFF8;

  // All ones keeps the timer interrupt quiet until software programs a compare value.
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } wb_state_t;

  // Replace the bytes of old_word selected by sel with the matching bytes of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_wb_responder_mtime_counter.sv
// mtime counter: prescaler plus 64-bit free-running mtime with a byte-masked write
// port split into 32-bit halves.
// Ports:
//   clock, reset         system clock, asynchronous active-low reset
//   wr_lo, wr_hi         write strobes for mtime[31:0] / mtime[63:32]
//   wr_sel               byte enables over the 64-bit word
//   wr_data              write data over the 64-bit word
//   mtime                current counter value
module clint_wb_responder_mtime_counter
  import clint_wb_responder_pkg::*;
#(
  parameter int unsigned CLOCK_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [7:0]  wr_sel,
  input  logic [63:0] wr_data,
  output logic [63:0] mtime
);

  localparam int unsigned PW = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_CYCLES - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          carry;
  logic [31:0]   lo_inc;
  logic [63:0]   mtime_next;

  always_comb begin
    tick            = (presc == PRESC_LAST);
    {carry, lo_inc} = {1'b0, mtime[31:0]} + {32'd0, tick};
    // A written half takes the merge over the pre-increment value, losing the tick.
    // Writing the low half also suppresses the carry into the high half.
    mtime_next[31:0] = wr_lo ? merge_bytes(mtime[31:0], wr_data[31:0], wr_sel[3:0]) : lo_inc;
    if (wr_hi) begin
      mtime_next[63:32] = merge_bytes(mtime[63:32], wr_data[63:32], wr_sel[7:4]);
    end else if (wr_lo) begin
      mtime_next[63:32] = mtime[63:32];
    end else begin
      mtime_next[63:32] = mtime[63:32] + {31'd0, carry};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      mtime <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      mtime <= mtime_next;
    end
  end

endmodule

// File: rtl/clint_wb_responder.sv
// Wishbone B4 classic responder for the core-local interruptor (msip, mtimecmp, mtime).
// Ports:
//   clock, reset                     system clock, asynchronous active-low reset
//   CYC_I, STB_I, WE_I, SEL_I,
//   ADR_I, DAT_I                     Wishbone request (ADR_I is a byte offset)
//   DAT_O, ACK_O                     registered Wishbone response
//   mem_msip, mem_mtime, mem_mtimecmp  raw register values for the core
//   software_interrupt               msip bit 0
//   timer_interrupt                  mtime >= mtimecmp (unsigned)
module clint_wb_responder
  import clint_wb_responder_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 32,  // 32 or 64
  parameter int unsigned CLOCK_CYCLES = 1    // >= 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   CYC_I,
  input  logic                   STB_I,
  input  logic                   WE_I,
  input  logic [DATA_SIZE/8-1:0] SEL_I,
  input  logic [15:0]            ADR_I,
  input  logic [DATA_SIZE-1:0]   DAT_I,
  output logic [DATA_SIZE-1:0]   DAT_O,
  output logic                   ACK_O,
  output logic [DATA_SIZE-1:0]   mem_msip,
  output logic [63:0]            mem_mtime,
  output logic [63:0]            mem_mtimecmp,
  output logic                   software_interrupt,
  output logic                   timer_interrupt
);

  localparam int unsigned SEL_W      = DATA_SIZE / 8;
  localparam int unsigned REPL       = 64 / DATA_SIZE;
  localparam bit          IS32       = (DATA_SIZE == 32);
  localparam logic [15:0] ALIGN_MASK = ~16'(SEL_W - 1);

  wb_state_t   state;
  logic        msip;
  logic [63:0] mtimecmp;
  logic [63:0] mtime;

  logic [15:0]          adr_word;
  logic                 hit_msip, cmp_lo, cmp_hi, tim_lo, tim_hi, rd_hi;
  logic                 accept, wr;
  logic [63:0]          wr_data64;
  logic [7:0]           wr_sel64;
  logic [63:0]          rd64;
  logic [DATA_SIZE-1:0] rd_word;

  // Decode: in 64-bit mode one access covers both halves of a 64-bit register.
  always_comb begin
    adr_word = ADR_I & ALIGN_MASK;
    hit_msip = (adr_word == MSIP_OFFSET);
    if (IS32) begin
      cmp_lo = (adr_word == MTIMECMP_OFFSET);
      cmp_hi = (adr_word == MTIMECMP_OFFSET + 16'h4);
      tim_lo = (adr_word == MTIME_OFFSET);
      tim_hi = (adr_word == MTIME_OFFSET + 16'h4);
    end else begin
      cmp_lo = (adr_word == MTIMECMP_OFFSET);
      cmp_hi = cmp_lo;
      tim_lo = (adr_word == MTIME_OFFSET);
      tim_hi = tim_lo;
    end
    rd_hi = IS32 & adr_word[2];
  end

  assign accept    = (state == IDLE) & CYC_I & STB_I;
  assign wr        = accept & WE_I;
  // A 32-bit bus lane lines up with either half of a 64-bit register.
  assign wr_data64 = {REPL{DAT_I}};
  assign wr_sel64  = {REPL{SEL_I}};

  always_comb begin
    rd64 = '0;
    if (hit_msip) begin
      rd64 = {63'd0, msip};
    end else if (cmp_lo | cmp_hi) begin
      rd64 = mtimecmp;
    end else if (tim_lo | tim_hi) begin
      rd64 = mtime;
    end
    rd_word = rd_hi ? DATA_SIZE'(rd64 >> 32) : DATA_SIZE'(rd64);
  end

  // Handshake: accept in IDLE, one-cycle ACK, always back to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ACK_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (CYC_I && STB_I) begin
            state <= ACK;
            ACK_O <= 1'b1;
            if (!WE_I) DAT_O <= rd_word;
          end
        end
        ACK: begin
          state <= IDLE;
          ACK_O <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ACK_O <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msip <= 1'b0;
    end else if (wr && hit_msip && SEL_I[0]) begin
      msip <= DAT_I[0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtimecmp <= MTIMECMP_RESET;
    end else begin
      if (wr && cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wr_data64[31:0],
                                                       wr_sel64[3:0]);
      if (wr && cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wr_data64[63:32],
                                                       wr_sel64[7:4]);
    end
  end

  clint_wb_responder_mtime_counter #(
    .CLOCK_CYCLES(CLOCK_CYCLES)
  ) u_mtime_counter (
    .clock  (clock),
    .reset  (reset),
    .wr_lo  (wr & tim_lo),
    .wr_hi  (wr & tim_hi),
    .wr_sel (wr_sel64),
    .wr_data(wr_data64),
    .mtime  (mtime)
  );

  assign mem_msip           = DATA_SIZE'(msip);
  assign mem_mtime          = mtime;
  assign mem_mtimecmp       = mtimecmp;
  assign software_interrupt = msip;
  assign timer_interrupt    = (mtime >= mtimecmp);

endmodule

// File: tb/tb_clint_wb_responder.sv
// Bench for clint_wb_responder (DATA_SIZE=32, CLOCK_CYCLES=1): directed scenarios plus
// random bus traffic, compared every cycle against a register-level model.
module tb_clint_wb_responder;

  localparam int unsigned DW = 32;
  localparam int unsigned CC = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [15:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [31:0] mem_msip;
  logic [63:0] mem_mtime, mem_mtimecmp;
  logic        sw_int, tim_int;

  always #5 clock = ~clock;

  clint_wb_responder #(
    .DATA_SIZE   (DW),
    .CLOCK_CYCLES(CC)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .CYC_I             (cyc),
    .STB_I             (stb),
    .WE_I              (we),
    .SEL_I             (sel),
    .ADR_I             (adr),
    .DAT_I             (dat_i),
    .DAT_O             (dat_o),
    .ACK_O             (ack_o),
    .mem_msip          (mem_msip),
    .mem_mtime         (mem_mtime),
    .mem_mtimecmp      (mem_mtimecmp),
    .software_interrupt(sw_int),
    .timer_interrupt   (tim_int)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mtime = '0;
  logic [63:0] m_cmp   = '1;
  logic        m_msip  = 1'b0;
  logic        m_ack   = 1'b0;
  logic [31:0] m_dat   = '0;
  int unsigned m_presc = 0;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_step();
    logic        tick, accept;
    logic [63:0] nxt;
    logic [15:0] w;
    tick    = (m_presc == CC - 1);
    m_presc = tick ? 0 : m_presc + 1;
    nxt     = m_mtime + (tick ? 64'd1 : 64'd0);
    accept  = !m_ack && cyc && stb;
    if (accept) begin
      w = adr & 16'hFFFC;
      if (we) begin
        case (w)
          16'h0000: if (sel[0]) m_msip = dat_i[0];
          16'h4000: m_cmp[31:0]  = mrg(m_cmp[31:0], dat_i, sel);
          16'h4004: m_cmp[63:32] = mrg(m_cmp[63:32], dat_i, sel);
          16'hBFF8: nxt = {m_mtime[63:32], mrg(m_mtime[31:0], dat_i, sel)};
          16'hBFFC: nxt = {mrg(m_mtime[63:32], dat_i, sel), nxt[31:0]};
          default: ;
        endcase
      end else begin
        case (w)
          16'h0000: m_dat = {31'd0, m_msip};
          16'h4000: m_dat = m_cmp[31:0];
          16'h4004: m_dat = m_cmp[63:32];
          16'hBFF8: m_dat = m_mtime[31:0];
          16'hBFFC: m_dat = m_mtime[63:32];
          default:  m_dat = '0;
        endcase
      end
    end
    m_ack   = accept;
    m_mtime = nxt;
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_mtime = '0; m_cmp = '1; m_msip = 1'b0; m_ack = 1'b0; m_dat = '0; m_presc = 0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial forever begin
    @(negedge clock);
    chk("ack", ack_o, m_ack);
    chk("dat_o", dat_o, m_dat);
    chk("mem_msip", mem_msip, {63'd0, m_msip});
    chk("mem_mtime", mem_mtime, m_mtime);
    chk("mem_mtimecmp", mem_mtimecmp, m_cmp);
    chk("sw_int", sw_int, m_msip);
    chk("timer_int", tim_int, m_mtime >= m_cmp);
  end

  // ---------------- stimulus ----------------
  // Called #1 after a clock edge with the responder idle; returns likewise.
  task automatic wb_xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdata);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    @(posedge clock); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("xfer_ack_rise", ack_o, 1);
    rdata = dat_o;
    @(posedge clock); #1;
    chk("xfer_ack_fall", ack_o, 0);
  endtask

  logic [31:0] r, target;
  logic [63:0] pre;
  int          n, acks;
  logic [15:0] addrs [8] = '{16'h0000, 16'h0004, 16'h4000, 16'h4004,
                             16'hBFF8, 16'hBFFC, 16'h1234, 16'h8000};

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mtime", mem_mtime, 64'd0);
    chk("rst_mtimecmp", mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_ack", ack_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_timer", tim_int, 0);
    chk("rst_sw", sw_int, 0);

    reset = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("mtime_after_10", mem_mtime, 64'd10);
    chk("cmp_after_10", mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("timer_after_10", tim_int, 0);
    chk("ack_after_10", ack_o, 0);

    // msip
    wb_xfer(1'b1, 16'h0000, 32'h1, 4'hF, r);
    chk("sw_int_set", sw_int, 1);
    wb_xfer(1'b0, 16'h0000, 32'h0, 4'h0, r);
    chk("msip_read", r, 32'h1);
    wb_xfer(1'b1, 16'h0000, 32'hFFFF_FFFE, 4'hF, r);
    chk("sw_int_clr", sw_int, 0);
    chk("msip_clr", mem_msip, 0);

    // Timer compare
    target = m_mtime[31:0] + 32'd20;
    wb_xfer(1'b1, 16'h4004, 32'h0, 4'hF, r);
    wb_xfer(1'b1, 16'h4000, target, 4'hF, r);
    chk("timer_before", tim_int, 0);
    n = 0;
    while (m_mtime[31:0] != target && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("timer_wait_mtime", mem_mtime, {32'd0, target});
    chk("timer_rise", tim_int, 1);
    wb_xfer(1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF, r);
    wb_xfer(1'b1, 16'h4004, 32'hFFFF_FFFF, 4'hF, r);
    chk("timer_clr", tim_int, 0);
    chk("cmp_ones", mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);

    // Partial mtime write racing an increment: write wins, no increment that cycle
    pre = m_mtime;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'hBFF8; dat_i = 32'hFFFF_FFFF; sel = 4'h3;
    @(posedge clock); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("mtime_merge", mem_mtime, {pre[63:16], 16'hFFFF});
    @(posedge clock); #1;
    chk("mtime_merge_next", mem_mtime, {pre[63:16], 16'hFFFF} + 64'd1);

    // Low word all ones: the following tick carries into the high word
    pre = m_mtime;
    wb_xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, r);
    chk("mtime_carry", mem_mtime, {pre[63:32] + 32'd1, 32'd0});
    wb_xfer(1'b1, 16'hBFFC, 32'h0, 4'hF, r);

    // Held request: an ACK every second cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'hBFF8;
    acks = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (ack_o) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_acks", acks, 3);
    wb_xfer(1'b0, 16'h1234, 32'h0, 4'h0, r);
    chk("unmapped_read", r, 0);

    // Random traffic
    repeat (400) begin
      cyc   = ($urandom_range(0, 3) != 0);
      stb   = ($urandom_range(0, 2) != 0);
      we    = $urandom_range(0, 1) == 1;
      adr   = addrs[$urandom_range(0, 7)] | 16'($urandom_range(0, 3));
      dat_i = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 600);
      sel   = 4'($urandom_range(0, 15));
      @(posedge clock); #1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset between request and ACK
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0000; dat_i = 32'h1; sel = 4'hF;
    #3 reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_no_ack", ack_o, 0);
    chk("abort_msip", mem_msip, 0);
    chk("abort_mtime", mem_mtime, 64'd0);
    chk("abort_cmp", mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("post_reset_mtime", mem_mtime, 64'd3);
    wb_xfer(1'b1, 16'h0000, 32'h1, 4'hF, r);
    chk("post_reset_sw", sw_int, 1);
    wb_xfer(1'b0, 16'h4004, 32'h0, 4'h0, r);
    chk("post_reset_cmp_hi", r, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
